// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer: per-stage enables and bubbles from load-use,
// EX redirect and data-memory wait hazards, with a memory timeout and perf counters.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             redirect_take,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_fault_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic rs1_hit_s;
    logic rs2_hit_s;
    logic luse_s;
    logic abort_s;
    logic mstall_s;
    logic stall_ev_s;

    // Hazard detection from current ID/EX/MEM inputs and wait state
    always_comb begin
        rs1_hit_s  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit_s  = id_use_rs2 && (id_rs2 == ex_rd);
        luse_s     = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
        abort_s    = (state_r == DMEM_WAIT) && (wait_cnt_r == WAIT_LAST) && !dmem_ready;
        mstall_s   = mem_req && !dmem_ready && !abort_s;
        stall_ev_s = mstall_s || (luse_s && !ex_redirect);
    end

    // Per-stage enable/flush selection; memory stall outranks redirect, which outranks load-use
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_flush  = abort_s;
        redirect_take = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mstall_s) begin
            // Redirect stays pending: the frozen EX stage keeps presenting it
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            redirect_take = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (luse_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            redirect_take = 1'b0;
        end
    end

    // Memory-wait FSM with timeout abort and one-cycle fault pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= '0;
            mem_fault_r <= 1'b0;
        end else begin
            mem_fault_r <= 1'b0;
            case (state_r)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        state_r    <= DMEM_WAIT;
                        wait_cnt_r <= WAIT_W'(1);
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                    end
                end
                DMEM_WAIT: begin
                    if (dmem_ready) begin
                        state_r    <= RUN;
                        wait_cnt_r <= '0;
                    end else if (abort_s) begin
                        state_r     <= RUN;
                        wait_cnt_r  <= '0;
                        mem_fault_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    // Stall and redirect-flush performance counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_ev_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (redirect_take) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign mem_fault = mem_fault_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed hazard scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipeline_stall_ctrl;
    localparam int MT = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, mem_wb_flush, redirect_take, mem_fault;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush), .redirect_take(redirect_take),
        .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Behavioural model: waited = cycles the current access has already spent not ready
    int            m_waited = 0;
    logic          m_fault  = 1'b0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_flush  = '0;

    always @(negedge clk) begin
        logic       luse_m, abort_m, mstall_m, rt_m;
        logic [8:0] exp_v, act_v;
        luse_m   = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        abort_m  = (m_waited == MT - 1) && !dmem_ready;
        mstall_m = mem_req && !dmem_ready && !abort_m;
        rt_m     = !rst && !mstall_m && ex_redirect;
        // order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en, memwb_fl, redirect
        if (rst)              exp_v = 9'b0_0_1_0_1_0_0_1_0;
        else if (mstall_m)    exp_v = 9'b0_0_0_0_0_0_1_1_0;
        else if (ex_redirect) exp_v = {7'b1_1_1_1_1_1_1, abort_m, 1'b1};
        else if (luse_m)      exp_v = {7'b0_0_0_1_1_1_1, abort_m, 1'b0};
        else                  exp_v = {7'b1_1_0_1_0_1_1, abort_m, 1'b0};
        act_v = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, mem_wb_en, mem_wb_flush, redirect_take};
        chk("model_outputs", {23'd0, act_v}, {23'd0, exp_v});
        chk("model_stall_cnt", {24'd0, stall_cnt}, {24'd0, m_stall});
        chk("model_flush_cnt", {24'd0, flush_cnt}, {24'd0, m_flush});
        chk("model_mem_fault", {31'd0, mem_fault}, {31'd0, m_fault});
        if (rst) begin
            m_waited = 0; m_fault = 1'b0; m_stall = '0; m_flush = '0;
        end else begin
            m_fault = abort_m;
            if (mstall_m || (luse_m && !ex_redirect)) m_stall = m_stall + 8'd1;
            if (rt_m) m_flush = m_flush + 8'd1;
            if (abort_m || dmem_ready) m_waited = 0;
            else if (m_waited > 0 || mem_req) m_waited = m_waited + 1;
            else m_waited = 0;
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        // Reset held for two cycles
        neg();
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        tick(); neg();
        chk("rst_if_id_flush", if_id_flush, 1'b1);
        chk("rst_id_ex_flush", id_ex_flush, 1'b1);
        chk("rst_mem_wb_flush", mem_wb_flush, 1'b1);
        chk("rst_mem_wb_en", mem_wb_en, 1'b0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        tick(); rst = 1'b0; neg();
        chk("run_pc_en", pc_en, 1'b1);
        chk("run_if_id_flush", if_id_flush, 1'b0);
        chk("run_mem_wb_flush", mem_wb_flush, 1'b0);

        // Load-use on rs2
        tick(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1; neg();
        chk("luse_pc_en", pc_en, 1'b0);
        chk("luse_if_id_en", if_id_en, 1'b0);
        chk("luse_id_ex_en", id_ex_en, 1'b1);
        chk("luse_id_ex_flush", id_ex_flush, 1'b1);
        tick(); clr(); neg();
        chk("luse_stall_cnt", stall_cnt, 32'd1);
        chk("luse_release_pc_en", pc_en, 1'b1);
        // x0 destination never stalls
        tick(); ex_mem_read = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; neg();
        chk("x0_pc_en", pc_en, 1'b1);
        chk("x0_id_ex_flush", id_ex_flush, 1'b0);
        // matching rs1 but not used, then used
        tick(); ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; neg();
        chk("unused_rs1_pc_en", pc_en, 1'b1);
        tick(); id_use_rs1 = 1'b1; neg();
        chk("rs1_luse_pc_en", pc_en, 1'b0);
        tick(); clr(); neg();
        chk("rs1_stall_cnt", stall_cnt, 32'd2);

        // Redirect and load-use together
        tick(); ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        id_use_rs1 = 1'b1; neg();
        chk("redir_take", redirect_take, 1'b1);
        chk("redir_if_id_flush", if_id_flush, 1'b1);
        chk("redir_id_ex_flush", id_ex_flush, 1'b1);
        chk("redir_pc_en", pc_en, 1'b1);
        tick(); clr(); neg();
        chk("redir_flush_cnt", flush_cnt, 32'd1);
        chk("redir_stall_cnt", stall_cnt, 32'd2);

        // Three wait cycles then ready
        tick(); mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            neg();
            chk("wait_pc_en", pc_en, 1'b0);
            chk("wait_ex_mem_en", ex_mem_en, 1'b0);
            chk("wait_mem_wb_flush", mem_wb_flush, 1'b1);
            chk("wait_if_id_flush", if_id_flush, 1'b0);
        end
        tick(); dmem_ready = 1'b1; neg();
        chk("ready_pc_en", pc_en, 1'b1);
        chk("ready_mem_wb_flush", mem_wb_flush, 1'b0);
        chk("wait_stall_cnt", stall_cnt, 32'd5);

        // Wait with pending redirect
        tick(); clr(); mem_req = 1'b1; ex_redirect = 1'b1; neg();
        chk("wredir_take_0", redirect_take, 1'b0);
        tick(); neg();
        chk("wredir_take_1", redirect_take, 1'b0);
        tick(); dmem_ready = 1'b1; neg();
        chk("wredir_take_ready", redirect_take, 1'b1);
        chk("wredir_if_id_flush", if_id_flush, 1'b1);
        tick(); clr(); neg();
        chk("wredir_flush_cnt", flush_cnt, 32'd2);
        chk("wredir_stall_cnt", stall_cnt, 32'd7);

        // Timeout: abort on the fourth not-ready cycle
        tick(); mem_req = 1'b1; neg();
        chk("to_c1_pc_en", pc_en, 1'b0);
        tick(); neg();
        chk("to_c2_pc_en", pc_en, 1'b0);
        tick(); neg();
        chk("to_c3_pc_en", pc_en, 1'b0);
        tick(); neg();
        chk("to_abort_pc_en", pc_en, 1'b1);
        chk("to_abort_mem_wb_flush", mem_wb_flush, 1'b1);
        chk("to_abort_mem_wb_en", mem_wb_en, 1'b1);
        chk("to_abort_fault", mem_fault, 1'b0);
        tick(); neg();
        chk("to_fault_pulse", mem_fault, 1'b1);
        chk("to_rewait_pc_en", pc_en, 1'b0);
        tick(); dmem_ready = 1'b1; neg();
        chk("to_fault_clear", mem_fault, 1'b0);
        chk("to_stall_cnt", stall_cnt, 32'd11);

        // Reset during the second wait cycle
        tick(); clr(); mem_req = 1'b1; neg();
        tick(); rst = 1'b1; neg();
        chk("rstw_pc_en", pc_en, 1'b0);
        chk("rstw_mem_wb_flush", mem_wb_flush, 1'b1);
        tick(); rst = 1'b0; clr(); neg();
        chk("rstw_stall_cnt", stall_cnt, 32'd0);
        chk("rstw_flush_cnt", flush_cnt, 32'd0);
        chk("rstw_fault", mem_fault, 1'b0);
        tick(); neg();
        chk("rstw_fault_later", mem_fault, 1'b0);
        // Fresh timeout must take the full four cycles again
        tick(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            neg();
            chk("rerun_wait_pc_en", pc_en, 1'b0);
        end
        tick(); neg();
        chk("rerun_abort_pc_en", pc_en, 1'b1);
        tick(); dmem_ready = 1'b1; neg();
        chk("rerun_fault", mem_fault, 1'b1);
        chk("rerun_stall_cnt", stall_cnt, 32'd3);

        // Counter wrap: 260 load-use cycles on an 8-bit counter
        tick(); clr(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        for (int i = 0; i < 259; i++) tick();
        tick(); clr(); neg();
        chk("wrap_stall_cnt", stall_cnt, 32'd7);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central sequencer for the 5-stage core's four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable/flush from three hazard sources: load-use, EX-stage redirect (branch/jump/jalr), and data-memory wait states.
- Small FSM tracks memory waits and enforces a timeout.
- Keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive data-memory wait cycles before fault abort (>=2)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination of instruction in EX
- ex_redirect  in  1  EX resolved taken branch/jump/jalr
- mem_req  in  1  instruction in MEM issues a data access
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID insert bubble
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX insert bubble (control fields zeroed)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- mem_wb_flush  out  1  MEM/WB insert bubble (reg_write=0)
- redirect_take  out  1  PC mux selects redirect target
- mem_fault  out  1  one-cycle pulse on data-memory timeout
- stall_cnt  out  CNT_W  cycles any stage was frozen
- flush_cnt  out  CNT_W  redirect flushes performed

Behaviour:
- State register: RUN, DMEM_WAIT. Registered: state, wait_cnt (clog2(MEM_TIMEOUT) bits), mem_fault, stall_cnt, flush_cnt.
- Reset (rst=1 at posedge): state=RUN, wait_cnt=0, mem_fault=0, counters=0.
- While rst is high, combinational outputs are forced: all *_en=0, if_id_flush=id_ex_flush=mem_wb_flush=1, redirect_take=0.
- mstall = mem_req & ~dmem_ready & ~abort.
  - abort = (state==DMEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1) & ~dmem_ready.
- luse = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority: mstall > ex_redirect > luse.
- mstall=1:
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0.
  - mem_wb_en=1, mem_wb_flush=1 (bubble into WB).
  - No other flush asserted; redirect_take=0 (redirect deferred; ex_redirect is held by frozen EX).
- else ex_redirect=1:
  - redirect_take=1, all en=1, if_id_flush=1, id_ex_flush=1.
  - luse ignored (wrong-path instruction).
- else luse=1: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
- else: all en=1, all flush=0, redirect_take=0.
- All outputs above are combinational from current inputs and state; zero-cycle latency.
- FSM transitions:
  - RUN: mem_req & ~dmem_ready -> DMEM_WAIT, wait_cnt<=1; else stay, wait_cnt<=0.
  - DMEM_WAIT, dmem_ready=1: -> RUN, wait_cnt<=0 (stage advances this cycle).
  - DMEM_WAIT, abort: -> RUN, wait_cnt<=0, mem_fault<=1 next cycle.
    - This cycle, mstall is deasserted and the pipeline advances with mem_wb_flush=1, so the faulting access never writes back.
  - DMEM_WAIT otherwise: wait_cnt<=wait_cnt+1.
- mem_fault is high for exactly one cycle after abort, then returns to 0.
- stall_cnt: +1 on every cycle with (mstall | (luse & ~ex_redirect)). Wraps modulo 2^CNT_W.
- flush_cnt: +1 every cycle redirect_take=1. Wraps modulo 2^CNT_W.
- Reset mid-wait: next state RUN, wait_cnt=0, pending access discarded, no fault pulse.
- ex_rd==0 never causes a load-use stall.

Test Plan:
- Reset: rst=1 for 2 cycles, all hazard inputs 0 -> all en=0, flushes=1, counters=0. After release -> all en=1, flushes=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Redirect + load-use same cycle: ex_redirect=1 plus luse condition -> redirect_take=1, if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait 3 cycles: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> freeze for 3 cycles, mem_wb_flush=1 each; state DMEM_WAIT; stall_cnt=3; advance on 4th cycle.
- Wait with redirect: mstall plus ex_redirect for 2 cycles -> redirect_take=0 during wait, then 1 in the cycle dmem_ready=1.
- Timeout, MEM_TIMEOUT=4: dmem_ready held 0 -> abort in cycle 4, mem_wb_flush=1, pipeline advances, mem_fault=1 for exactly cycle 5. Reset asserted at wait cycle 2 in a rerun -> no fault, state RUN.
